// File: rtl/z80_int_pkg.sv
// rtl/z80_int_pkg.sv - shared types and constants for the IM2 interrupt controller
package z80_int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } intState_e;

    localparam logic [1:0] REG_VEC  = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_EOI  = 2'd2;

    // Low nibble of the vector handed out when an acknowledge finds nothing to serve
    localparam logic [3:0] SPURIOUS_LO = 4'b1110;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - strict-priority source picker that honours in-service nesting
module int_prio_enc #(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] isr,
    output logic             valid,
    output logic [1:0]       idx
);

    logic blocked;

    // Walk from source 0 upward; once an in-service bit is seen nothing at or below it may win
    always_comb begin
        valid   = 1'b0;
        idx     = 2'd0;
        blocked = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            blocked = blocked | isr[i];
            if (!valid && req[i] && !blocked) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
    end

endmodule

// File: rtl/z80_im2_int_ctrl.sv
// rtl/z80_im2_int_ctrl.sv - Z80 mode-2 vectored interrupt controller at I/O ports IO_BASE..+3
module z80_im2_int_ctrl
    import z80_int_pkg::*;
#(
    parameter int          N_SRC   = 4,
    parameter logic [7:0]  IO_BASE = 8'h84
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_m1_n,
    input  logic             cpu_iorq_n,
    input  logic             cpu_rd_n,
    input  logic             cpu_wr_n,
    input  logic [7:0]       cpu_addr,
    input  logic [7:0]       cpu_dout,
    input  logic [N_SRC-1:0] irq_n,
    output logic             int_n,
    output logic [7:0]       data_out,
    output logic             data_oe
);

    // Bus decode; cpuClock is derived from clk so strobes are used unsynchronised
    logic sel, ack, ioRd, ioWr;
    assign sel  = (cpu_addr[7:2] == IO_BASE[7:2]);
    assign ack  = !cpu_m1_n && !cpu_iorq_n;
    assign ioRd = !cpu_iorq_n && !cpu_rd_n && cpu_m1_n && sel;
    assign ioWr = !cpu_iorq_n && !cpu_wr_n && sel;

    logic [N_SRC-1:0] irqMeta, irqSync;
    logic             ackPrev, wrPrev;
    logic [3:0]       vecBase;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] isr;
    intState_e        state;
    logic             intNReg;
    logic             ackOe;
    logic [7:0]       vecOut;

    // Device lines are asynchronous to clk: two-flop synchroniser, idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqMeta <= '1;
            irqSync <= '1;
        end else begin
            irqMeta <= irq_n;
            irqSync <= irqMeta;
        end
    end

    logic [N_SRC-1:0] pending, req;
    assign pending = ~irqSync;
    assign req     = pending & mask;

    // Previous strobe levels so a long bus cycle acts only on its first clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ackPrev <= 1'b0;
            wrPrev  <= 1'b0;
        end else begin
            ackPrev <= ack;
            wrPrev  <= ioWr;
        end
    end

    logic wrRise, ackRise, eoiStrobe;
    assign wrRise    = ioWr && !wrPrev;
    assign ackRise   = ack && !ackPrev;
    assign eoiStrobe = wrRise && (cpu_addr[1:0] == REG_EOI);

    // Vector base and mask registers, written once per I/O write cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vecBase <= 4'h0;
            mask    <= '0;
        end else if (wrRise) begin
            if (cpu_addr[1:0] == REG_VEC)
                vecBase <= cpu_dout[7:4];
            else if (cpu_addr[1:0] == REG_MASK)
                mask <= cpu_dout[N_SRC-1:0];
        end
    end

    logic       candValid;
    logic [1:0] candIdx;

    int_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req   (req),
        .isr   (isr),
        .valid (candValid),
        .idx   (candIdx)
    );

    // EOI drops the highest-priority in-service bit (lowest set bit)
    logic [N_SRC-1:0] isrAfterEoi, isrWithWin;
    logic [7:0]       ackVec, spurVec;
    assign isrAfterEoi = eoiStrobe ? (isr & (isr - N_SRC'(1))) : isr;
    assign isrWithWin  = isrAfterEoi | (N_SRC'(1) << candIdx);
    assign ackVec      = {vecBase, 1'b0, candIdx, 1'b0};
    assign spurVec     = {vecBase, SPURIOUS_LO};

    // Request / acknowledge sequencer; owns int_n, the latched vector and the in-service set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            intNReg <= 1'b1;
            ackOe   <= 1'b0;
            vecOut  <= 8'h00;
            isr     <= '0;
        end else begin
            isr <= isrAfterEoi;
            case (state)
                IDLE: begin
                    if (ackRise) begin
                        vecOut <= spurVec;
                        ackOe  <= 1'b1;
                        state  <= ACK;
                    end else if (candValid) begin
                        intNReg <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ackRise) begin
                        intNReg <= 1'b1;
                        ackOe   <= 1'b1;
                        state   <= ACK;
                        if (candValid) begin
                            isr    <= isrWithWin;
                            vecOut <= ackVec;
                        end else begin
                            vecOut <= spurVec;
                        end
                    end else if (!candValid) begin
                        intNReg <= 1'b1;
                        state   <= IDLE;
                    end
                end
                ACK: begin
                    if (!ack) begin
                        ackOe <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    intNReg <= 1'b1;
                    ackOe   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Register read mux; reserved offset reads all ones
    logic [7:0] regRdData;
    always_comb begin
        regRdData = 8'hFF;
        case (cpu_addr[1:0])
            REG_VEC:  regRdData = 8'(pending);
            REG_MASK: regRdData = 8'(mask);
            REG_EOI:  regRdData = 8'(isr);
            default:  regRdData = 8'hFF;
        endcase
    end

    assign int_n    = intNReg;
    assign data_oe  = ioRd || ackOe;
    assign data_out = ioRd ? regRdData : vecOut;

endmodule

// File: tb/tb_z80_im2_int_ctrl.sv
// tb/tb_z80_im2_int_ctrl.sv - directed self-checking bench for z80_im2_int_ctrl
module tb_z80_im2_int_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_m1_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0] cpu_addr, cpu_dout;
    logic [3:0] irq_n;
    logic       int_n;
    logic [7:0] data_out;
    logic       data_oe;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    z80_im2_int_ctrl #(
        .N_SRC   (4),
        .IO_BASE (8'h84)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_m1_n   (cpu_m1_n),
        .cpu_iorq_n (cpu_iorq_n),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .irq_n      (irq_n),
        .int_n      (int_n),
        .data_out   (data_out),
        .data_oe    (data_oe)
    );

    typedef struct {
        logic       isWr;
        logic [1:0] off;
        logic [7:0] data;
    } regVec_t;

    regVec_t tbl[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic holdWrite(input logic [1:0] off, input logic [7:0] d, input int n);
        cpu_addr   = {6'b100001, off};
        cpu_dout   = d;
        cpu_iorq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        tick(n);
        cpu_iorq_n = 1'b1;
        cpu_wr_n   = 1'b1;
        tick(1);
    endtask

    task automatic ioRead(input logic [1:0] off, input logic [7:0] exp, input string name);
        cpu_addr   = {6'b100001, off};
        cpu_iorq_n = 1'b0;
        cpu_rd_n   = 1'b0;
        #1;
        check({name, " oe"}, {7'd0, data_oe}, 8'h01);
        check(name, data_out, exp);
        tick(1);
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        #1;
        check({name, " oe off"}, {7'd0, data_oe}, 8'h00);
        tick(1);
    endtask

    task automatic ackCycle(input logic [7:0] exp, input string name);
        cpu_m1_n   = 1'b0;
        cpu_iorq_n = 1'b0;
        tick(2);
        check({name, " oe"}, {7'd0, data_oe}, 8'h01);
        check({name, " vec"}, data_out, exp);
        check({name, " int_n"}, {7'd0, int_n}, 8'h01);
        cpu_m1_n   = 1'b1;
        cpu_iorq_n = 1'b1;
        tick(2);
        check({name, " oe end"}, {7'd0, data_oe}, 8'h00);
    endtask

    task automatic waitIntLow(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            tick(1);
            if (int_n == 1'b0) break;
        end
        check(name, {7'd0, int_n}, 8'h00);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{1'b0, 2'd1, 8'h00};
        tbl[2]  = '{1'b1, 2'd1, 8'h0F};
        tbl[3]  = '{1'b0, 2'd1, 8'h0F};
        tbl[4]  = '{1'b0, 2'd0, 8'h00};
        tbl[5]  = '{1'b0, 2'd3, 8'hFF};
        tbl[6]  = '{1'b1, 2'd3, 8'h55};
        tbl[7]  = '{1'b0, 2'd3, 8'hFF};
        tbl[8]  = '{1'b0, 2'd1, 8'h0F};
        tbl[9]  = '{1'b0, 2'd2, 8'h00};
        tbl[10] = '{1'b1, 2'd1, 8'h05};
        tbl[11] = '{1'b0, 2'd1, 8'h05};
        tbl[12] = '{1'b1, 2'd1, 8'h0F};

        reset      = 1'b1;
        cpu_m1_n   = 1'b1;
        cpu_iorq_n = 1'b1;
        cpu_rd_n   = 1'b1;
        cpu_wr_n   = 1'b1;
        cpu_addr   = 8'h00;
        cpu_dout   = 8'h00;
        irq_n      = 4'hF;
        tick(3);
        reset = 1'b0;
        tick(2);

        check("reset int_n", {7'd0, int_n}, 8'h01);
        check("reset data_oe", {7'd0, data_oe}, 8'h00);
        check("reset data_out", data_out, 8'h00);
        ioRead(2'd1, 8'h00, "reset mask");
        ioRead(2'd2, 8'h00, "reset isr");

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].isWr)
                holdWrite(tbl[i].off, tbl[i].data, 2);
            else
                ioRead(tbl[i].off, tbl[i].data, $sformatf("tbl%0d", i));
        end

        // Source 2 request and acknowledge
        irq_n[2] = 1'b0;
        waitIntLow(3, "irq2 int_n");
        ackCycle(8'hA4, "ack irq2");
        ioRead(2'd2, 8'h04, "isr after irq2");
        ioRead(2'd0, 8'h04, "pending irq2");

        // Lower priority waits, higher priority nests
        irq_n[3] = 1'b0;
        tick(5);
        check("irq3 blocked", {7'd0, int_n}, 8'h01);
        irq_n[0] = 1'b0;
        waitIntLow(4, "irq0 nests");
        ackCycle(8'hA0, "ack irq0");
        ioRead(2'd2, 8'h05, "isr nested");
        irq_n[0] = 1'b1;
        tick(3);
        holdWrite(2'd2, 8'h00, 5);
        ioRead(2'd2, 8'h04, "eoi once");
        check("after eoi int_n", {7'd0, int_n}, 8'h01);
        irq_n[2] = 1'b1;
        irq_n[3] = 1'b1;
        tick(3);
        holdWrite(2'd2, 8'h00, 2);
        ioRead(2'd2, 8'h00, "isr cleared");
        holdWrite(2'd2, 8'h00, 2);
        ioRead(2'd2, 8'h00, "eoi noop");

        // Request that vanishes before ack, then spurious ack
        irq_n[1] = 1'b0;
        waitIntLow(3, "irq1 pulse req");
        irq_n[1] = 1'b1;
        tick(4);
        check("irq1 withdrawn", {7'd0, int_n}, 8'h01);
        ackCycle(8'hAE, "spurious");
        ioRead(2'd2, 8'h00, "isr after spurious");

        // Long write cycle and masked pending source
        holdWrite(2'd1, 8'h01, 5);
        ioRead(2'd1, 8'h01, "mask held write");
        irq_n[1] = 1'b0;
        tick(5);
        check("masked irq1", {7'd0, int_n}, 8'h01);
        ioRead(2'd0, 8'h02, "pending masked");

        // Reset in the middle of an acknowledge
        holdWrite(2'd1, 8'h0F, 2);
        waitIntLow(3, "irq1 unmasked");
        cpu_m1_n   = 1'b0;
        cpu_iorq_n = 1'b0;
        tick(2);
        check("pre-reset oe", {7'd0, data_oe}, 8'h01);
        check("pre-reset vec", data_out, 8'hA2);
        #2;
        reset = 1'b1;
        #1;
        check("async reset oe", {7'd0, data_oe}, 8'h00);
        check("async reset int_n", {7'd0, int_n}, 8'h01);
        check("async reset data_out", data_out, 8'h00);
        cpu_m1_n   = 1'b1;
        cpu_iorq_n = 1'b1;
        irq_n      = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(3);
        ioRead(2'd0, 8'h00, "post-reset pending");
        ioRead(2'd1, 8'h00, "post-reset mask");
        ioRead(2'd2, 8'h00, "post-reset isr");
        ackCycle(8'h0E, "post-reset vec_base");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
